// File: rtl/str_ram_buf_pkg.sv
// ---------------------------------------------------------------------------
// str_ram_buf_pkg
// Shared definitions for the string RAM buffer:
//   str_state_e : stream-out FSM state encoding
//   DEPTH       : storage depth for the default address width
//   depth_of()  : depth helper for any address width (2**aw)
// ---------------------------------------------------------------------------
package str_ram_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } str_state_e;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEPTH      = 2 ** DEF_ADDR_W;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/str_ram_dp.sv
// ---------------------------------------------------------------------------
// str_ram_dp
// Simple dual-port storage array: one write port, one registered read port.
// Read-first: a read and a write to the same address in the same cycle
// returns the old contents. No reset on the array or the read register.
// Ports:
//   clk            rising-edge clock
//   we/waddr/wdata write port
//   re/raddr       read request; rdata updates the cycle after re=1
//   rdata          registered read data (holds when re=0)
// ---------------------------------------------------------------------------
module str_ram_dp
  import str_ram_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [depth_of(ADDR_W)];

  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/str_ram_buf.sv
// ---------------------------------------------------------------------------
// str_ram_buf
// Character/string buffer built on a simple dual-port RAM.
//   - random write (wr/addr/dat_in) and random read (rd/addr -> dat_out,
//     rd_valid one cycle later)
//   - append port (app_wr/app_dat) writing at the tail, tracked by len/full
//   - stream-out engine replaying ram[0..len-1] on str_valid/str_ready
// Ports:
//   clk, rst (async, active-high), en (global freeze when 0)
//   wr, rd, addr, dat_in, dat_out, rd_valid   random access
//   app_wr, app_dat, app_ack                  append
//   clr, len, full                            length control / status
//   str_start, str_ready, str_valid, str_dat, str_busy, str_done  stream
//
// Stream handshake: str_dat is valid while str_valid=1 and stays stable until
// a cycle with str_valid=1 and str_ready=1; that cycle transfers the
// character. str_valid never depends combinationally on str_ready.
// ---------------------------------------------------------------------------
module str_ram_buf
  import str_ram_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dat_in,
  output logic [DATA_W-1:0] dat_out,
  output logic              rd_valid,
  input  logic              app_wr,
  input  logic [DATA_W-1:0] app_dat,
  output logic              app_ack,
  input  logic              clr,
  output logic [ADDR_W:0]   len,
  output logic              full,
  input  logic              str_start,
  input  logic              str_ready,
  output logic              str_valid,
  output logic [DATA_W-1:0] str_dat,
  output logic              str_busy,
  output logic              str_done
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(depth_of(ADDR_W));

  str_state_e        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   slen;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] dat_hold;

  logic              app_ok;
  logic              rd_ok;

  assign full     = (len == LEN_MAX);
  assign str_busy = (state != ST_IDLE);

  // Random write wins the write port; clr and full also drop the append.
  assign app_ok = en & app_wr & ~wr & ~clr & ~full;
  // The stream owns the read port whenever the FSM is not idle.
  assign rd_ok  = en & rd & (state == ST_IDLE);

  always_comb begin
    ram_we    = (en & wr) | app_ok;
    ram_waddr = wr ? addr : len[ADDR_W-1:0];
    ram_wdata = wr ? dat_in : app_dat;
    ram_re    = (en & (state == ST_FETCH)) | rd_ok;
    ram_raddr = (state == ST_FETCH) ? idx : addr;
  end

  str_ram_dp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_q)
  );

  // The RAM read register is shared with the stream, so a random-read result
  // is captured into dat_hold once its rd_valid cycle is over; dat_out then
  // holds even if the stream later reuses the read register.
  assign dat_out = rd_valid ? ram_q : dat_hold;

  // During HOLD nothing else can issue a read, so ram_q is stable.
  assign str_dat = (state == ST_HOLD) ? ram_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len      <= '0;
      app_ack  <= 1'b0;
      rd_valid <= 1'b0;
      dat_hold <= '0;
    end else if (en) begin
      app_ack  <= app_ok;
      rd_valid <= rd_ok;
      if (rd_valid) dat_hold <= ram_q;
      if (clr)         len <= '0;
      else if (app_ok) len <= len + (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      slen      <= '0;
      str_valid <= 1'b0;
      str_done  <= 1'b0;
    end else if (en) begin
      if (clr) begin
        // Abort: no end-of-stream pulse for a cleared stream.
        state     <= ST_IDLE;
        str_valid <= 1'b0;
        str_done  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            str_done <= 1'b0;
            if (str_start) begin
              if (len != '0) begin
                slen  <= len;
                idx   <= '0;
                state <= ST_FETCH;
              end else begin
                state    <= ST_DONE;
                str_done <= 1'b1;
              end
            end
          end
          ST_FETCH: begin
            state     <= ST_HOLD;
            str_valid <= 1'b1;
          end
          ST_HOLD: begin
            if (str_ready) begin
              str_valid <= 1'b0;
              if ({1'b0, idx} == slen - (ADDR_W + 1)'(1)) begin
                state    <= ST_DONE;
                str_done <= 1'b1;
              end else begin
                idx   <= idx + ADDR_W'(1);
                state <= ST_FETCH;
              end
            end
          end
          ST_DONE: begin
            str_done <= 1'b0;
            state    <= ST_IDLE;
          end
          default: begin
            state     <= ST_IDLE;
            str_valid <= 1'b0;
            str_done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_str_ram_buf.sv
// ---------------------------------------------------------------------------
// tb_str_ram_buf
// Directed bench for str_ram_buf (DATA_W=8, ADDR_W=8). Inputs change 1 ns
// after a rising edge; outputs are sampled at the same point, so each check
// sees the state produced by the edge just passed.
// ---------------------------------------------------------------------------
module tb_str_ram_buf;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] dat_in = '0;
  logic [DW-1:0] dat_out;
  logic          rd_valid;
  logic          app_wr = 1'b0;
  logic [DW-1:0] app_dat = '0;
  logic          app_ack;
  logic          clr = 1'b0;
  logic [AW:0]   len;
  logic          full;
  logic          str_start = 1'b0;
  logic          str_ready = 1'b0;
  logic          str_valid;
  logic [DW-1:0] str_dat;
  logic          str_busy;
  logic          str_done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q[$];

  str_ram_buf #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wr       (wr),
    .rd       (rd),
    .addr     (addr),
    .dat_in   (dat_in),
    .dat_out  (dat_out),
    .rd_valid (rd_valid),
    .app_wr   (app_wr),
    .app_dat  (app_dat),
    .app_ack  (app_ack),
    .clr      (clr),
    .len      (len),
    .full     (full),
    .str_start(str_start),
    .str_ready(str_ready),
    .str_valid(str_valid),
    .str_dat  (str_dat),
    .str_busy (str_busy),
    .str_done (str_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic idle_in();
    en        = 1'b1;
    wr        = 1'b0;
    rd        = 1'b0;
    app_wr    = 1'b0;
    clr       = 1'b0;
    str_start = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic append(input logic [DW-1:0] d);
    app_wr  = 1'b1;
    app_dat = d;
    tick();
    app_wr  = 1'b0;
  endtask

  // Follow a running stream from the current sample until str_done or the
  // cycle budget runs out; every transferred character is scoreboarded.
  task automatic run_stream(input int max_cyc, output int n_chars, output int n_done);
    n_chars = 0;
    n_done  = 0;
    for (int c = 0; c < max_cyc; c++) begin
      chk("stream_busy", 32'(str_busy), 1);
      if (str_valid && str_ready) begin
        n_chars++;
        if (exp_q.size() > 0) chk("stream_dat", 32'(str_dat), 32'(exp_q.pop_front()));
      end
      if (str_done) begin
        n_done++;
        break;
      end
      tick();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          en;
    logic          wr;
    logic          rd;
    logic          app;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] adat;
    logic          e_ack;
    logic [AW:0]   e_len;
    logic          e_rv;
    logic          e_dc;
    logic [DW-1:0] e_dat;
  } vec_t;

  function automatic vec_t mk(input logic v_en, input logic v_wr, input logic v_rd,
                              input logic v_app, input logic [AW-1:0] v_addr,
                              input logic [DW-1:0] v_din, input logic [DW-1:0] v_adat,
                              input logic v_ack, input logic [AW:0] v_len,
                              input logic v_rv, input logic v_dc, input logic [DW-1:0] v_dat);
    vec_t v;
    v.en = v_en; v.wr = v_wr; v.rd = v_rd; v.app = v_app;
    v.addr = v_addr; v.din = v_din; v.adat = v_adat;
    v.e_ack = v_ack; v.e_len = v_len; v.e_rv = v_rv; v.e_dc = v_dc; v.e_dat = v_dat;
    return v;
  endfunction

  vec_t vt[17];

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int nc, nd, cnt;

    //            en wr rd ap addr  din    adat   ack len    rv dc dat
    vt[0]  = mk(1, 0, 0, 1, 8'd0, 8'h00, 8'h48, 1, 9'd1, 0, 0, 8'h00);
    vt[1]  = mk(1, 0, 0, 1, 8'd0, 8'h00, 8'h69, 1, 9'd2, 0, 0, 8'h00);
    vt[2]  = mk(1, 0, 1, 0, 8'd1, 8'h00, 8'h00, 0, 9'd2, 1, 1, 8'h69);
    vt[3]  = mk(1, 0, 0, 0, 8'd0, 8'h00, 8'h00, 0, 9'd2, 0, 1, 8'h69);
    vt[4]  = mk(1, 1, 0, 1, 8'd3, 8'h11, 8'h22, 0, 9'd2, 0, 0, 8'h00);
    vt[5]  = mk(1, 0, 1, 0, 8'd3, 8'h00, 8'h00, 0, 9'd2, 1, 1, 8'h11);
    vt[6]  = mk(1, 0, 1, 0, 8'd0, 8'h00, 8'h00, 0, 9'd2, 1, 1, 8'h48);
    vt[7]  = mk(1, 1, 1, 0, 8'd0, 8'h55, 8'h00, 0, 9'd2, 1, 1, 8'h48);
    vt[8]  = mk(1, 0, 1, 0, 8'd0, 8'h00, 8'h00, 0, 9'd2, 1, 1, 8'h55);
    vt[9]  = mk(1, 0, 0, 1, 8'd0, 8'h00, 8'h21, 1, 9'd3, 0, 1, 8'h55);
    vt[10] = mk(1, 0, 1, 0, 8'd2, 8'h00, 8'h00, 0, 9'd3, 1, 1, 8'h21);
    vt[11] = mk(1, 0, 0, 1, 8'd0, 8'h00, 8'h3f, 1, 9'd4, 0, 1, 8'h21);
    vt[12] = mk(0, 0, 1, 1, 8'd0, 8'h00, 8'h40, 1, 9'd4, 0, 1, 8'h21);
    vt[13] = mk(1, 0, 0, 0, 8'd0, 8'h00, 8'h00, 0, 9'd4, 0, 0, 8'h00);
    vt[14] = mk(1, 0, 1, 0, 8'd3, 8'h00, 8'h00, 0, 9'd4, 1, 1, 8'h3f);
    vt[15] = mk(0, 0, 0, 0, 8'd0, 8'h00, 8'h00, 0, 9'd4, 1, 1, 8'h3f);
    vt[16] = mk(1, 0, 0, 0, 8'd0, 8'h00, 8'h00, 0, 9'd4, 0, 1, 8'h3f);

    // Reset state
    tick();
    tick();
    chk("rst_len", 32'(len), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_dat_out", 32'(dat_out), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_app_ack", 32'(app_ack), 0);
    chk("rst_str_valid", 32'(str_valid), 0);
    chk("rst_str_dat", 32'(str_dat), 0);
    chk("rst_str_done", 32'(str_done), 0);
    chk("rst_str_busy", 32'(str_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    tick();

    // Random access / append / arbitration / enable vectors
    foreach (vt[i]) begin
      en = vt[i].en; wr = vt[i].wr; rd = vt[i].rd; app_wr = vt[i].app;
      addr = vt[i].addr; dat_in = vt[i].din; app_dat = vt[i].adat;
      tick();
      idle_in();
      chk($sformatf("vec%0d_app_ack", i), 32'(app_ack), 32'(vt[i].e_ack));
      chk($sformatf("vec%0d_len", i), 32'(len), 32'(vt[i].e_len));
      chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vt[i].e_rv));
      if (vt[i].e_dc) chk($sformatf("vec%0d_dat_out", i), 32'(dat_out), 32'(vt[i].e_dat));
    end

    // Fresh "Hi" string
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_len", 32'(len), 0);
    append(8'h48);
    append(8'h69);
    chk("hi_len", 32'(len), 2);

    // Stream with consumer always ready
    str_ready = 1'b1;
    str_start = 1'b1;
    tick();
    str_start = 1'b0;
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    run_stream(20, nc, nd);
    chk("s2_chars", 32'(nc), 2);
    chk("s2_done", 32'(nd), 1);
    tick();
    chk("s2_done_pulse", 32'(str_done), 0);
    chk("s2_busy_end", 32'(str_busy), 0);

    // Back-pressure, read-port ownership, write into unfetched index, freeze
    str_ready = 1'b0;
    str_start = 1'b1;
    tick();
    str_start = 1'b0;
    tick();
    chk("s3_valid", 32'(str_valid), 1);
    chk("s3_dat", 32'(str_dat), 'h48);
    for (int k = 0; k < 5; k++) begin
      rd = (k == 1);
      wr = (k == 3);
      addr = 8'd1;
      dat_in = 8'h6a;
      tick();
      rd = 1'b0;
      wr = 1'b0;
      chk("s3_hold_valid", 32'(str_valid), 1);
      chk("s3_hold_dat", 32'(str_dat), 'h48);
      chk("s3_rd_blocked", 32'(rd_valid), 0);
    end
    chk("s3_dat_out_kept", 32'(dat_out), 'h3f);
    en = 1'b0;
    str_ready = 1'b1;
    tick();
    tick();
    chk("s3_freeze_valid", 32'(str_valid), 1);
    chk("s3_freeze_dat", 32'(str_dat), 'h48);
    en = 1'b1;
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h6a);
    run_stream(20, nc, nd);
    chk("s3_chars", 32'(nc), 2);
    chk("s3_done", 32'(nd), 1);
    tick();

    // Fill to capacity
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      app_wr = 1'b1;
      app_dat = 8'(i);
      tick();
      if (i == 254) begin
        chk("fill_len_255", 32'(len), 255);
        chk("fill_not_full", 32'(full), 0);
      end
    end
    app_wr = 1'b0;
    chk("fill_len_256", 32'(len), 256);
    chk("fill_full", 32'(full), 1);
    chk("fill_last_ack", 32'(app_ack), 1);
    append(8'hff);
    chk("full_drop_ack", 32'(app_ack), 0);
    chk("full_drop_len", 32'(len), 256);

    // Stream the full buffer, then clear mid-stream
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    str_ready = 1'b1;
    str_start = 1'b1;
    tick();
    str_start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      if (str_valid && str_ready) begin
        cnt++;
        if (exp_q.size() > 0) chk("s5_dat", 32'(str_dat), 32'(exp_q.pop_front()));
      end
    end
    chk("s5_chars", 32'(cnt), 3);
    chk("s5_valid_before_clr", 32'(str_valid), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("s5_clr_len", 32'(len), 0);
    chk("s5_clr_full", 32'(full), 0);
    chk("s5_clr_valid", 32'(str_valid), 0);
    chk("s5_clr_busy", 32'(str_busy), 0);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (str_done) cnt++;
      tick();
    end
    chk("s5_no_done", 32'(cnt), 0);
    exp_q.delete();

    // Empty string stream
    str_start = 1'b1;
    tick();
    str_start = 1'b0;
    chk("s6_done", 32'(str_done), 1);
    chk("s6_valid", 32'(str_valid), 0);
    chk("s6_busy", 32'(str_busy), 1);
    tick();
    chk("s6_done_end", 32'(str_done), 0);
    chk("s6_busy_end", 32'(str_busy), 0);
    chk("s6_valid_end", 32'(str_valid), 0);

    // Asynchronous reset in the middle of HOLD
    append(8'h48);
    str_ready = 1'b0;
    str_start = 1'b1;
    tick();
    str_start = 1'b0;
    tick();
    chk("s6_hold_valid", 32'(str_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_str_valid", 32'(str_valid), 0);
    chk("arst_str_dat", 32'(str_dat), 0);
    chk("arst_str_busy", 32'(str_busy), 0);
    chk("arst_str_done", 32'(str_done), 0);
    chk("arst_dat_out", 32'(dat_out), 0);
    chk("arst_rd_valid", 32'(rd_valid), 0);
    chk("arst_app_ack", 32'(app_ack), 0);
    chk("arst_len", 32'(len), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/str_ram_buf.md
Name: str_ram_buf

Overview:
- Parametrised successor of the string RAM: simple dual-port RAM (one write port, one read port) for character/string storage.
- Keeps random-access read/write under an enable gate.
- Adds an append port that writes at a tail pointer and tracks string length.
- Adds a stream-out engine that replays stored string 0..len-1 over a valid/ready handshake to downstream consumers (UART/display formatters).

Parameters:
DATA_W, 8, character width in bits
ADDR_W, 8, address width; depth = 2**ADDR_W entries

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
en  in  1  global enable; when 0 all requests ignored, all state/outputs hold
wr  in  1  random write strobe
rd  in  1  random read strobe
addr  in  ADDR_W  random-access address
dat_in  in  DATA_W  random write data
dat_out  out  DATA_W  random read data
rd_valid  out  1  dat_out updated this cycle (1-cycle pulse)
app_wr  in  1  append strobe
app_dat  in  DATA_W  append data
app_ack  out  1  append accepted (registered pulse)
clr  in  1  clear length to 0, abort stream
len  out  ADDR_W+1  current string length, 0..2**ADDR_W
full  out  1  len == 2**ADDR_W
str_start  in  1  start streaming
str_ready  in  1  consumer ready
str_valid  out  1  str_dat valid
str_dat  out  DATA_W  streamed character
str_busy  out  1  stream FSM not IDLE
str_done  out  1  one-cycle end-of-stream pulse

Behaviour:
- Reset: len=0, FSM=IDLE, idx=0, dat_out=0, rd_valid=0, app_ack=0, str_valid=0, str_dat=0, str_done=0. RAM contents not reset.
- All effects below require en=1; en=0 freezes FSM, counters and outputs, including pulses; stream resumes when en returns.
- Write arbitration:
  - wr has priority over app_wr. When both are asserted, the append is dropped (app_ack=0, len unchanged).
  - app_wr when full: dropped, app_ack=0.
- Append:
  - ram[len] <= app_dat; len <= len+1; app_ack=1 next cycle.
- Random read:
  - rd latched, dat_out = ram[addr] one cycle later with rd_valid=1.
  - Same-cycle write to the same address returns old data (read-first).
- Read port sharing: when str_busy=1, rd is ignored (rd_valid stays 0). The stream owns the read port.
- Clear:
  - clr sets len=0 and forces FSM to IDLE, deasserting str_valid next cycle with no str_done.
  - clr has priority over app_wr in the same cycle (append dropped).
- Stream FSM:
  - IDLE: on str_start with len>0, snapshot slen=len, set idx=0, go to FETCH. On str_start with len=0, go to DONE.
  - FETCH: read ram[idx], go to HOLD. Next cycle str_dat=data and str_valid=1.
  - HOLD: str_valid=1, str_dat stable until str_ready=1. On ready: if idx==slen-1 go to DONE, else idx+1 and go to FETCH. str_valid drops in FETCH (max throughput 1 char per 2 cycles).
  - DONE: str_done=1 for one cycle, then IDLE.
  - str_start is ignored while busy.
- Writes and appends during streaming are allowed:
  - Stream length stays at the snapshot.
  - A write to an index not yet fetched is visible in the stream.
- Wrap-around: len saturates at 2**ADDR_W; the tail never wraps.

Decomposition:
- Shared package: stream FSM state enum (IDLE, FETCH, HOLD, DONE) and DEPTH = 2**ADDR_W.
- One sub-module: str_ram_dp, a parametrised simple dual-port storage array with registered read-first read port, no reset.
- Control, append logic and FSM live in the top level.

Test Plan:
1. Reset then append 'H','i' (0x48,0x69) -> app_ack pulses, len=2; rd addr 1 -> next cycle dat_out=0x69, rd_valid=1.
2. str_start with str_ready=1 on len=2 -> str_valid shows 0x48 then 0x69, then str_done pulses once; str_busy high throughout.
3. Hold str_ready=0 for 5 cycles in HOLD -> str_dat 0x48 stable, str_valid stays 1; a rd pulse during the stream gives rd_valid=0.
4. wr addr 3 = 0x11 and app_wr 0x22 same cycle -> ram[3]=0x11, app_ack=0, len unchanged.
5. Fill to 256 appends (ADDR_W=8) -> full=1, len=256; next append dropped; clr mid-stream -> len=0, str_valid drops, no str_done.
6. str_start with len=0 -> str_done next cycle, str_valid never asserted; assert rst mid-HOLD -> all outputs 0 immediately.
